neuron_layer_train_sequencer: RTL and testbench
===============================================

# neuron_layer_train_sequencer

Training/evaluation sequencer for a 4-output learning neuron layer (`neuron_learn_layer4`-style datapath). It fetches input/expected vectors from an external sample store over a req/ack handshake, presents them to the layer, waits a fixed settle time, then pulses a learn cycle. It also accumulates per-epoch absolute output error and repeats over a programmable number of samples and epochs. It sits between the sample memory and the layer and is the only driver of the layer's `valid`, `learn`, `in` and `expected_out`.

## Interface
- `N`, 16: layer input width in `zero2one_t` elements.
- `M`, 4: layer output count.
- `DEPTH`, 64: maximum samples per epoch; `AW = $clog2(DEPTH)`.
- `SETTLE`, 2: cycles between the present pulse and sampling `layer_out`; must be ≥ 1.
- `ERR_W`, `$bits(zero2one_t)+$clog2(M*DEPTH)+1`: error accumulator width.

- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin run; ignored while `busy`.
- `abort` in 1: terminate run.
- `sample_count` in AW+1: samples per epoch, sampled on `start`.
- `epochs` in 8: epoch count, sampled on `start`.
- `train_mode` in 1: 1 = learn, 0 = evaluate only; sampled on `start`.
- `smp_req` out 1: sample fetch request.
- `smp_addr` out AW: sample index.
- `smp_ack` in 1: sample data valid this cycle.
- `smp_in` in zero2one_t[N]: sample input vector.
- `smp_expected` in zero2one_t[M]: sample target vector.
- `layer_valid` out 1, `layer_learn` out 1: layer controls.
- `layer_in` out zero2one_t[N], `layer_expected_out` out zero2one_t[M]: registered sample.
- `layer_out` in zero2one_t[M]: layer result.
- `busy` out 1, `done` out 1: `done` is a one-cycle pulse.
- `sample_idx` out AW, `epoch_idx` out 8: current position.
- `err_accum` out ERR_W: running error for the current epoch.
- `last_epoch_err` out ERR_W: error total of the most recently completed epoch.

## Operation
- States: IDLE, FETCH, PRESENT, SETTLE, LEARN, NEXT, DONE.
- IDLE: `busy`=0. On `start`:
  - If `sample_count`=0 or `epochs`=0, go to DONE.
  - Otherwise latch the config, clear indices and `err_accum`, and go to FETCH.
- FETCH:
  - `smp_req`=1, `smp_addr`=`sample_idx`, both held stable until `smp_ack`.
  - In the ack cycle, capture `smp_in`/`smp_expected` into the `layer_in`/`layer_expected_out` registers and go to PRESENT.
  - `smp_ack` while `smp_req`=0 is ignored.
- PRESENT: `layer_valid`=1, `layer_learn`=0 for exactly one cycle, then go to SETTLE.
- SETTLE:
  - Count SETTLE cycles.
  - In the last cycle, add Σ|`layer_out[i]`−`layer_expected_out[i]`| over i<M to `err_accum`, saturating at all-ones.
  - Go to LEARN if `train_mode`, else NEXT.
- LEARN: `layer_valid`=1, `layer_learn`=1 for one cycle, then go to NEXT.
- NEXT:
  - If `sample_idx`≠`sample_count`−1: increment `sample_idx`, go to FETCH.
  - Else:
    - `last_epoch_err`←`err_accum`, clear `err_accum`, `sample_idx`←0.
    - If `epoch_idx`=`epochs`−1, go to DONE; else increment `epoch_idx` and go to FETCH.
- DONE: `done`=1 for one cycle, `busy`=0, then go to IDLE. Indices and `last_epoch_err` hold.
- `abort` while busy:
  - Next state is IDLE and `smp_req` drops next cycle.
  - No `done` pulse, no learn pulse; `last_epoch_err` is not updated.
  - `abort` beats `smp_ack` in the same cycle, so no capture occurs.
- `layer_in`/`layer_expected_out` are stable from capture until the next ack capture.

## Timing
- Reset values: all outputs 0, including the `layer_in`/`layer_expected_out` registers; state IDLE.
- `start` in cycle t puts FETCH (`smp_req`=1) at t+1; `busy` rises at t+1.
- With `smp_ack` a cycles after FETCH entry:
  - present pulse at +a+1.
  - `layer_out` sampled at +a+1+SETTLE.
  - learn pulse at +a+2+SETTLE.
  - NEXT at +a+3+SETTLE.
  - next FETCH at +a+4+SETTLE.
- Cycles per sample at zero ack latency: SETTLE+4 when training, SETTLE+3 when evaluating.
- Zero-count `start` at t gives `done` at t+1 with `busy` never asserted.
- `start` coincident with `abort` in IDLE: `abort` wins and `start` is ignored.

## Test plan
- SETTLE=2, `sample_count`=3, `epochs`=2, `train_mode`=1, `smp_ack` the same cycle as `smp_req`, `start` at cycle 0 -> `done` at cycle 37; 12 `layer_valid` pulses, 6 with `layer_learn`; `smp_addr` sequence 0,1,2,0,1,2.
- Same setup with `train_mode`=0 -> no `layer_learn`; `done` at cycle 31.
- Ack delayed 5 cycles on sample 1 -> `smp_req`/`smp_addr` held 6 cycles; `layer_in` unchanged until capture; `done` shifts by 5.
- Error check: `layer_out` forced all-ones, expected all-zero, `sample_count`=2 -> `last_epoch_err`=2·M·max(zero2one_t); `err_accum` clears at the epoch boundary.
- `abort` asserted in the SETTLE of sample 1, together with an `smp_ack` -> IDLE next cycle, no learn pulse, no `done`, no capture.
- `start` with `epochs`=0 -> `done` the next cycle, `busy` stays 0; `reset` asserted mid-run -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/neuron_layer_train_sequencer_if.sv
// Sample-store fetch handshake plus the layer control/data bus driven by the train sequencer.
interface neuron_layer_train_sequencer_if #(
  parameter type zero2one_t = logic [7:0],
  parameter int  N          = 16,
  parameter int  M          = 4,
  parameter int  AW         = 6
);
  localparam int ZW = $bits(zero2one_t);

  logic                 smp_req;
  logic [AW-1:0]        smp_addr;
  logic                 smp_ack;
  logic [N-1:0][ZW-1:0] smp_in;
  logic [M-1:0][ZW-1:0] smp_expected;

  logic                 layer_valid;
  logic                 layer_learn;
  logic [N-1:0][ZW-1:0] layer_in;
  logic [M-1:0][ZW-1:0] layer_expected_out;
  logic [M-1:0][ZW-1:0] layer_out;

  modport master (
    output smp_req, smp_addr,
    input  smp_ack, smp_in, smp_expected,
    output layer_valid, layer_learn, layer_in, layer_expected_out,
    input  layer_out
  );

  modport slave (
    input  smp_req, smp_addr,
    output smp_ack, smp_in, smp_expected,
    input  layer_valid, layer_learn, layer_in, layer_expected_out,
    output layer_out
  );
endinterface

// File: rtl/neuron_layer_train_sequencer.sv
// Train/evaluate sequencer: fetch sample over req/ack, present, settle SETTLE cycles, optional
// learn pulse, accumulate per-epoch |out - expected|; SETTLE+4 cycles/sample (SETTLE+3 evaluating).
module neuron_layer_train_sequencer #(
  parameter type zero2one_t = logic [7:0],
  parameter int  N          = 16,
  parameter int  M          = 4,
  parameter int  DEPTH      = 64,
  parameter int  AW         = $clog2(DEPTH),
  parameter int  SETTLE     = 2,
  parameter int  ERR_W      = $bits(zero2one_t) + $clog2(M * DEPTH) + 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [AW:0]                    sample_count,
  input  logic [7:0]                     epochs,
  input  logic                           train_mode,
  neuron_layer_train_sequencer_if.master bus,
  output logic                           busy,
  output logic                           done,
  output logic [AW-1:0]                  sample_idx,
  output logic [7:0]                     epoch_idx,
  output logic [ERR_W-1:0]               err_accum,
  output logic [ERR_W-1:0]               last_epoch_err
);
  localparam int ZW  = $bits(zero2one_t);
  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_PRESENT, S_SETTLE, S_LEARN, S_NEXT, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [AW:0]          cfg_count;
  logic [7:0]           cfg_epochs;
  logic                 cfg_train;
  logic [SCW-1:0]       settle_cnt;
  logic [N-1:0][ZW-1:0] in_q;
  logic [M-1:0][ZW-1:0] exp_q;
  logic [ZW-1:0]        diff;
  logic [ERR_W:0]       err_sum, err_wide;
  logic [ERR_W-1:0]     err_next;
  logic                 run_active, start_ok, zero_cfg, capture;
  logic                 last_settle, last_sample, last_epoch;

  assign run_active  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign start_ok    = (state_q == S_IDLE) && start && !abort;
  assign zero_cfg    = (sample_count == '0) || (epochs == '0);
  assign capture     = (state_q == S_FETCH) && bus.smp_ack && !abort;
  assign last_settle = (settle_cnt == SCW'(SETTLE - 1));
  assign last_sample = ({1'b0, sample_idx} == cfg_count - 1'b1);
  assign last_epoch  = (epoch_idx == cfg_epochs - 8'd1);

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort && run_active) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (start_ok) state_d = zero_cfg ? S_DONE : S_FETCH;
        S_FETCH:   if (bus.smp_ack) state_d = S_PRESENT;
        S_PRESENT: state_d = S_SETTLE;
        S_SETTLE:  if (last_settle) state_d = cfg_train ? S_LEARN : S_NEXT;
        S_LEARN:   state_d = S_NEXT;
        S_NEXT:    state_d = (last_sample && last_epoch) ? S_DONE : S_FETCH;
        S_DONE:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.smp_req            = (state_q == S_FETCH);
    bus.smp_addr           = sample_idx;
    bus.layer_valid        = (state_q == S_PRESENT) || (state_q == S_LEARN);
    bus.layer_learn        = (state_q == S_LEARN);
    bus.layer_in           = in_q;
    bus.layer_expected_out = exp_q;
    busy                   = run_active;
    done                   = (state_q == S_DONE);
  end

  // Sum of absolute per-output errors, added to the running total with saturation.
  always_comb begin
    diff    = '0;
    err_sum = '0;
    for (int i = 0; i < M; i++) begin
      diff    = (bus.layer_out[i] >= exp_q[i]) ? bus.layer_out[i] - exp_q[i]
                                                : exp_q[i] - bus.layer_out[i];
      err_sum = err_sum + (ERR_W + 1)'(diff);
    end
    err_wide = {1'b0, err_accum} + err_sum;
    err_next = err_wide[ERR_W] ? '1 : err_wide[ERR_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cfg_count      <= '0;
      cfg_epochs     <= '0;
      cfg_train      <= 1'b0;
      settle_cnt     <= '0;
      in_q           <= '0;
      exp_q          <= '0;
      sample_idx     <= '0;
      epoch_idx      <= '0;
      err_accum      <= '0;
      last_epoch_err <= '0;
    end else begin
      if (start_ok && !zero_cfg) begin
        cfg_count  <= sample_count;
        cfg_epochs <= epochs;
        cfg_train  <= train_mode;
        sample_idx <= '0;
        epoch_idx  <= '0;
        err_accum  <= '0;
      end
      if (capture) begin
        in_q  <= bus.smp_in;
        exp_q <= bus.smp_expected;
      end
      if (state_q == S_SETTLE && !last_settle) settle_cnt <= settle_cnt + 1'b1;
      else                                     settle_cnt <= '0;
      if (state_q == S_SETTLE && last_settle && !abort) err_accum <= err_next;
      if (state_q == S_NEXT && !abort) begin
        if (last_sample) begin
          last_epoch_err <= err_accum;
          err_accum      <= '0;
          sample_idx     <= '0;
          if (!last_epoch) epoch_idx <= epoch_idx + 8'd1;
        end else begin
          sample_idx <= sample_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_neuron_layer_train_sequencer.sv
// Directed bench for neuron_layer_train_sequencer: sample data is a function of smp_addr,
// layer_out is a constant, and timing/count/error results are compared to hand-derived values.
module tb_neuron_layer_train_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, abort, train_mode;
  logic [6:0]  sample_count;
  logic [7:0]  epochs;
  logic        busy, done;
  logic [5:0]  sample_idx;
  logic [7:0]  epoch_idx;
  logic [16:0] err_accum, last_epoch_err;

  neuron_layer_train_sequencer_if bus ();

  neuron_layer_train_sequencer dut (
    .clock(clk), .reset(reset), .start(start), .abort(abort),
    .sample_count(sample_count), .epochs(epochs), .train_mode(train_mode),
    .bus(bus), .busy(busy), .done(done), .sample_idx(sample_idx),
    .epoch_idx(epoch_idx), .err_accum(err_accum), .last_epoch_err(last_epoch_err)
  );

  always #5 clk = ~clk;

  // Sample store model: optional one-off 5-cycle ack delay on address 1.
  logic       slow_en, slow_used, ack_force, zero_exp;
  logic [7:0] lo_val;
  int         req_cnt;

  always @(posedge clk) begin
    req_cnt <= (bus.smp_req && !bus.smp_ack) ? req_cnt + 1 : 0;
    if (!slow_en) slow_used <= 1'b0;
    else if (bus.smp_ack && bus.smp_req && bus.smp_addr == 6'd1) slow_used <= 1'b1;
  end

  always_comb begin
    bus.smp_ack = ack_force ||
                  (bus.smp_req && (!(slow_en && !slow_used && bus.smp_addr == 6'd1) || req_cnt >= 5));
    for (int j = 0; j < 16; j++) bus.smp_in[j] = 8'(int'(bus.smp_addr) * 32 + j);
    for (int j = 0; j < 4; j++)
      bus.smp_expected[j] = zero_exp ? 8'd0 : 8'(int'(bus.smp_addr) * 16 + j);
    bus.layer_out = {4{lo_val}};
  end

  int checks, failures;
  int done_cyc, done_cnt, valid_cnt, learn_cnt, first_busy, first_valid, first_learn;
  int req_run, max_req_run, stable_viol;
  logic [31:0]  addr_seq;
  logic [5:0]   prev_addr;
  logic [127:0] prev_in;
  logic [16:0]  err_ep1, err_s1;
  logic         got_ep1, got_s1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [6:0] cnt, input logic [7:0] ep, input logic tm,
                     input int budget, input int abort_at, input int reset_at);
    repeat (2) @(negedge clk);
    sample_count = cnt; epochs = ep; train_mode = tm;
    start = 1'b1; abort = (abort_at == 0);
    done_cyc = -1; done_cnt = 0; valid_cnt = 0; learn_cnt = 0;
    first_busy = -1; first_valid = -1; first_learn = -1;
    req_run = 0; max_req_run = 0; stable_viol = 0; addr_seq = '0;
    got_ep1 = 1'b0; got_s1 = 1'b0; err_ep1 = '1; err_s1 = '1;
    for (int rel = 1; rel <= budget; rel++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; ack_force = 1'b0; reset = 1'b0;
      if (bus.layer_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = rel;
      end
      if (bus.layer_learn) begin
        learn_cnt++;
        if (first_learn < 0) first_learn = rel;
      end
      if (bus.smp_req) begin
        req_run++;
        if (req_run > max_req_run) max_req_run = req_run;
        if (req_run > 1 && (bus.smp_addr != prev_addr || bus.layer_in != prev_in)) stable_viol++;
        if (bus.smp_ack) addr_seq = {addr_seq[27:0], 4'(bus.smp_addr)};
        if (epoch_idx == 8'd1 && !got_ep1) begin err_ep1 = err_accum; got_ep1 = 1'b1; end
        if (sample_idx == 6'd1 && !got_s1) begin err_s1 = err_accum; got_s1 = 1'b1; end
      end else begin
        req_run = 0;
      end
      prev_addr = bus.smp_addr;
      prev_in   = bus.layer_in;
      if (busy && first_busy < 0) first_busy = rel;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = rel;
      end
      if (rel == abort_at) begin abort = 1'b1; ack_force = 1'b1; end
      if (rel == reset_at) reset = 1'b1;
      if (done) break;
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; train_mode = 1'b0;
    sample_count = '0; epochs = '0;
    slow_en = 1'b0; ack_force = 1'b0; zero_exp = 1'b0; lo_val = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", {busy, done, bus.smp_req, bus.layer_valid, bus.layer_learn}, 0);
    chk("reset_layer_in", bus.layer_in, 0);
    chk("reset_regs", {err_accum, last_epoch_err, sample_idx, epoch_idx, bus.smp_addr, bus.layer_expected_out}, 0);

    // Training, 3 samples x 2 epochs, zero ack latency; layer_out = 0 so error = sum of expected.
    run(7'd3, 8'd2, 1'b1, 60, -1, -1);
    chk("train_done_cycle", done_cyc, 37);
    chk("train_done_count", done_cnt, 1);
    chk("train_valid_pulses", valid_cnt, 12);
    chk("train_learn_pulses", learn_cnt, 6);
    chk("train_addr_seq", addr_seq, 32'h0001_2012);
    chk("train_busy_rise", first_busy, 1);
    chk("train_first_present", first_valid, 2);
    chk("train_first_learn", first_learn, 5);
    chk("train_busy_at_done", busy, 0);
    chk("train_err_sample0", err_s1, 6);
    chk("train_last_epoch_err", last_epoch_err, 210);
    chk("train_err_cleared", err_accum, 0);
    chk("train_epoch_idx", epoch_idx, 1);
    chk("train_layer_in0", bus.layer_in[0], 64);
    chk("train_layer_in15", bus.layer_in[15], 79);
    chk("train_layer_exp3", bus.layer_expected_out[3], 35);

    // Evaluate only.
    run(7'd3, 8'd2, 1'b0, 60, -1, -1);
    chk("eval_done_cycle", done_cyc, 31);
    chk("eval_learn_pulses", learn_cnt, 0);
    chk("eval_valid_pulses", valid_cnt, 6);

    // Ack delayed 5 cycles on the first fetch of sample 1.
    slow_en = 1'b1;
    run(7'd3, 8'd2, 1'b1, 80, -1, -1);
    slow_en = 1'b0;
    chk("slow_done_cycle", done_cyc, 42);
    chk("slow_req_hold", max_req_run, 6);
    chk("slow_stability", stable_viol, 0);
    chk("slow_addr_seq", addr_seq, 32'h0001_2012);

    // All-ones outputs vs all-zero targets.
    zero_exp = 1'b1; lo_val = 8'hFF;
    run(7'd2, 8'd2, 1'b1, 60, -1, -1);
    chk("err_done_cycle", done_cyc, 25);
    chk("err_sample0", err_s1, 1020);
    chk("err_epoch_boundary", err_ep1, 0);
    chk("err_last_epoch", last_epoch_err, 2040);
    chk("err_final_accum", err_accum, 0);

    // Abort in the first SETTLE cycle of sample 1 with a spurious ack.
    zero_exp = 1'b0;
    run(7'd3, 8'd1, 1'b1, 14, 9, -1);
    chk("abort_settle_learn", learn_cnt, 1);
    chk("abort_settle_valid", valid_cnt, 3);
    chk("abort_settle_done", done_cnt, 0);
    chk("abort_settle_idle", {busy, bus.smp_req}, 0);
    chk("abort_settle_last_err", last_epoch_err, 2040);
    chk("abort_settle_accum", err_accum, 1014);
    chk("abort_settle_layer_in", bus.layer_in[0], 32);

    // Abort in FETCH coincident with ack: no capture.
    run(7'd3, 8'd1, 1'b1, 4, 1, -1);
    chk("abort_fetch_layer_in", bus.layer_in[0], 32);
    chk("abort_fetch_valid", valid_cnt, 0);
    chk("abort_fetch_idle", busy, 0);

    // Zero-count starts and start+abort in IDLE.
    run(7'd3, 8'd0, 1'b1, 5, -1, -1);
    chk("zero_epochs_done", done_cyc, 1);
    chk("zero_epochs_busy", first_busy, -1);
    run(7'd0, 8'd2, 1'b1, 5, -1, -1);
    chk("zero_count_done", done_cyc, 1);
    run(7'd3, 8'd2, 1'b1, 5, 0, -1);
    chk("start_abort_done", done_cnt, 0);
    chk("start_abort_busy", first_busy, -1);

    // Reset mid-run (sample 1 SETTLE).
    run(7'd3, 8'd2, 1'b1, 10, -1, 9);
    chk("midreset_ctrl", {busy, done, bus.smp_req, bus.layer_valid, bus.layer_learn}, 0);
    chk("midreset_layer_in", bus.layer_in, 0);
    chk("midreset_regs", {err_accum, last_epoch_err, sample_idx, epoch_idx, bus.smp_addr, bus.layer_expected_out}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
